mc_controller: RTL and testbench

//  Multi-cycle MIPS control FSM, successor to the single-cycle decoder-based controller.

---
 rtl/mc_ctrl_pkg.sv | 72 +++++++
 rtl/mc_op_decode.sv | 43 ++++
 rtl/mc_controller.sv | 182 ++++++++++++++++++
 tb/tb_mc_controller.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs, FSM states,
// latched operation classes and the datapath control codes it drives.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_OR   = 3'd2;
  localparam logic [2:0] ALU_LUI  = 3'd3;

  localparam logic [2:0] NPC_SEQ    = 3'd0;
  localparam logic [2:0] NPC_BRANCH = 3'd1;
  localparam logic [2:0] NPC_JUMP   = 3'd2;
  localparam logic [2:0] NPC_JR     = 3'd3;

  // Register-file destination / write-data selects share one code space.
  localparam logic [1:0] REG_RT_ALU = 2'd0;
  localparam logic [1:0] REG_RD_MEM = 2'd1;
  localparam logic [1:0] REG_RA_PC4 = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_e;

  typedef enum logic [3:0] {
    C_NOP,
    C_ADDU,
    C_SUBU,
    C_JR,
    C_ORI,
    C_LUI,
    C_LW,
    C_SW,
    C_BEQ,
    C_J,
    C_JAL
  } op_class_e;

  function automatic logic [1:0] wb_dst(input op_class_e c);
    case (c)
      C_ADDU, C_SUBU: wb_dst = REG_RD_MEM;
      C_JAL:          wb_dst = REG_RA_PC4;
      default:        wb_dst = REG_RT_ALU;
    endcase
  endfunction

  function automatic logic [1:0] wb_src(input op_class_e c);
    case (c)
      C_LW:    wb_src = REG_RD_MEM;
      C_JAL:   wb_src = REG_RA_PC4;
      default: wb_src = REG_RT_ALU;
    endcase
  endfunction

endpackage

// File: rtl/mc_op_decode.sv
// Combinational instruction classifier: maps the IR word to an operation class and
// flags anything outside the supported subset, which then executes as a nop.
module mc_op_decode
  import mc_ctrl_pkg::*;
(
  input  logic [31:0] i_instr,
  output op_class_e   o_class,
  output logic        o_illegal
);

  logic [5:0] w_op;
  logic [5:0] w_funct;

  assign w_op    = i_instr[31:26];
  assign w_funct = i_instr[5:0];

  // NOTE: both outputs are assigned before the case so no path through it can infer a latch.
  always_comb begin
    o_class   = C_NOP;
    o_illegal = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        case (w_funct)
          FN_ADDU: o_class = C_ADDU;
          FN_SUBU: o_class = C_SUBU;
          FN_JR:   o_class = C_JR;
          // Only the canonical all-zero word is a supported sll.
          FN_SLL:  o_illegal = (i_instr != 32'h0);
          default: o_illegal = 1'b1;
        endcase
      end
      OP_J:    o_class = C_J;
      OP_JAL:  o_class = C_JAL;
      OP_BEQ:  o_class = C_BEQ;
      OP_ORI:  o_class = C_ORI;
      OP_LUI:  o_class = C_LUI;
      OP_LW:   o_class = C_LW;
      OP_SW:   o_class = C_SW;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) with req/ready memory handshakes.
// Optional performance counters are built when MC_PERF_CNT_EN is defined.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 3,
  parameter int NPCOP_W = 3,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instr,
  output logic               imReq,
  input  logic               imReady,
  output logic               dmReq,
  input  logic               dmReady,
  output logic               irWE,
  output logic               pcWE,
  output logic               pcCondWE,
  output logic [NPCOP_W-1:0] nextPCop,
  output logic [ALUOP_W-1:0] aluOp,
  output logic               aluSrc,
  output logic               usExt,
  output logic [1:0]         regDesCtrl,
  output logic [1:0]         regDataCtrl,
  output logic               regWE,
  output logic               dmWE,
  output logic               dmRE,
  output logic               illegal,
  output logic [CNT_W-1:0]   cycleCnt,
  output logic [CNT_W-1:0]   instrCnt
);

  state_e    r_state;
  state_e    w_next;
  op_class_e r_class;
  op_class_e w_dec_class;
  logic      w_dec_illegal;
  // Low for the first cycle after a reset edge so every output reads 0 then.
  logic      r_run;

  mc_op_decode u_decode (
    .i_instr   (instr),
    .o_class   (w_dec_class),
    .o_illegal (w_dec_illegal)
  );

  // NOTE: non-blocking assignments so every register samples pre-edge values together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_class <= C_NOP;
      r_run   <= 1'b0;
    end else begin
      r_run   <= 1'b1;
      r_state <= w_next;
      if (r_state == S_DECODE) r_class <= w_dec_class;
    end
  end

  always_comb begin
    w_next      = r_state;
    imReq       = 1'b0;
    dmReq       = 1'b0;
    irWE        = 1'b0;
    pcWE        = 1'b0;
    pcCondWE    = 1'b0;
    nextPCop    = NPCOP_W'(NPC_SEQ);
    aluOp       = ALUOP_W'(ALU_ADD);
    aluSrc      = 1'b0;
    usExt       = 1'b0;
    regDesCtrl  = REG_RT_ALU;
    regDataCtrl = REG_RT_ALU;
    regWE       = 1'b0;
    dmWE        = 1'b0;
    dmRE        = 1'b0;
    illegal     = 1'b0;
    if (r_run) begin
      case (r_state)
        S_FETCH: begin
          imReq = 1'b1;
          // The only ready-dependent outputs: IR and PC+4 load in the accept cycle.
          if (imReady) begin
            irWE     = 1'b1;
            pcWE     = 1'b1;
            nextPCop = NPCOP_W'(NPC_SEQ);
            w_next   = S_DECODE;
          end
        end
        S_DECODE: begin
          illegal = w_dec_illegal;
          case (w_dec_class)
            C_J: begin
              pcWE     = 1'b1;
              nextPCop = NPCOP_W'(NPC_JUMP);
              w_next   = S_FETCH;
            end
            C_JR: begin
              pcWE     = 1'b1;
              nextPCop = NPCOP_W'(NPC_JR);
              w_next   = S_FETCH;
            end
            C_NOP:   w_next = S_FETCH;
            C_JAL:   w_next = S_WB;
            default: w_next = S_EXEC;
          endcase
        end
        S_EXEC: begin
          w_next = S_WB;
          case (r_class)
            C_ADDU: aluOp = ALUOP_W'(ALU_ADD);
            C_SUBU: aluOp = ALUOP_W'(ALU_SUB);
            C_ORI: begin
              aluOp  = ALUOP_W'(ALU_OR);
              aluSrc = 1'b1;
              usExt  = 1'b1;
            end
            C_LUI: begin
              aluOp  = ALUOP_W'(ALU_LUI);
              aluSrc = 1'b1;
            end
            C_LW, C_SW: begin
              aluOp  = ALUOP_W'(ALU_ADD);
              aluSrc = 1'b1;
              w_next = S_MEM;
            end
            C_BEQ: begin
              aluOp    = ALUOP_W'(ALU_SUB);
              pcCondWE = 1'b1;
              nextPCop = NPCOP_W'(NPC_BRANCH);
              w_next   = S_FETCH;
            end
            default: w_next = S_FETCH;
          endcase
        end
        S_MEM: begin
          dmReq = 1'b1;
          dmRE  = (r_class == C_LW);
          dmWE  = (r_class == C_SW);
          if (dmReady) w_next = (r_class == C_LW) ? S_WB : S_FETCH;
        end
        S_WB: begin
          regWE       = 1'b1;
          regDesCtrl  = wb_dst(r_class);
          regDataCtrl = wb_src(r_class);
          if (r_class == C_JAL) begin
            pcWE     = 1'b1;
            nextPCop = NPCOP_W'(NPC_JUMP);
          end
          w_next = S_FETCH;
        end
        default: w_next = S_FETCH;
      endcase
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instr_cnt;
  logic             w_retire;

  // An instruction retires on any return to FETCH from another state.
  assign w_retire = (r_state != S_FETCH) && (w_next == S_FETCH);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      if (w_retire) r_instr_cnt <= r_instr_cnt + CNT_W'(1);
    end
  end

  assign cycleCnt = r_cycle_cnt;
  assign instrCnt = r_instr_cnt;
`else
  assign cycleCnt = '0;
  assign instrCnt = '0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed ISA cases, a mid-MEM reset, then random
// instructions with random memory wait states, scored per instruction by a transaction model.
module tb_mc_controller;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        imReq, imReady, dmReq, dmReady;
  logic        irWE, pcWE, pcCondWE;
  logic [2:0]  nextPCop, aluOp;
  logic        aluSrc, usExt;
  logic [1:0]  regDesCtrl, regDataCtrl;
  logic        regWE, dmWE, dmRE, illegal;
  logic [31:0] cycleCnt, instrCnt;

  int n_vec  = 0;
  int n_miss = 0;
  int m_ret  = 0;
  int m_cyc  = 0;

  mc_controller #(.ALUOP_W(3), .NPCOP_W(3), .CNT_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .imReq       (imReq),
    .imReady     (imReady),
    .dmReq       (dmReq),
    .dmReady     (dmReady),
    .irWE        (irWE),
    .pcWE        (pcWE),
    .pcCondWE    (pcCondWE),
    .nextPCop    (nextPCop),
    .aluOp       (aluOp),
    .aluSrc      (aluSrc),
    .usExt       (usExt),
    .regDesCtrl  (regDesCtrl),
    .regDataCtrl (regDataCtrl),
    .regWE       (regWE),
    .dmWE        (dmWE),
    .dmRE        (dmRE),
    .illegal     (illegal),
    .cycleCnt    (cycleCnt),
    .instrCnt    (instrCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference for the cycle counter: counts every clock edge seen with reset high.
  always @(posedge clk) m_cyc <= reset ? m_cyc + 1 : 0;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef enum {K_ADDU, K_SUBU, K_JR, K_ORI, K_LUI, K_LW, K_SW, K_BEQ,
                K_J, K_JAL, K_NOP, K_ILL} kind_e;

  typedef struct packed {
    logic [3:0] lat;      // cycles with zero-wait memories
    logic       wb;
    logic [1:0] des;
    logic [1:0] dat;
    logic       cpc;      // PC load outside the fetch cycle
    logic [2:0] cpc_npc;
    logic       beq;
    logic       mem;
    logic       lw;
    logic       ill;
    logic       ex;
    logic [2:0] alu;
    logic       src;
    logic       ext;
  } exp_t;

  function automatic kind_e classify(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    case (op)
      6'h00: begin
        if (ins == 32'h0)      classify = K_NOP;
        else if (fn == 6'h21)  classify = K_ADDU;
        else if (fn == 6'h23)  classify = K_SUBU;
        else if (fn == 6'h08)  classify = K_JR;
        else                   classify = K_ILL;
      end
      6'h02:   classify = K_J;
      6'h03:   classify = K_JAL;
      6'h04:   classify = K_BEQ;
      6'h0D:   classify = K_ORI;
      6'h0F:   classify = K_LUI;
      6'h23:   classify = K_LW;
      6'h2B:   classify = K_SW;
      default: classify = K_ILL;
    endcase
  endfunction

  function automatic exp_t expect_of(input kind_e k);
    exp_t e;
    e = '0;
    case (k)
      K_ADDU: begin e.lat = 4; e.wb = 1; e.des = 1; e.ex = 1; e.alu = 0; end
      K_SUBU: begin e.lat = 4; e.wb = 1; e.des = 1; e.ex = 1; e.alu = 1; end
      K_ORI:  begin e.lat = 4; e.wb = 1; e.ex = 1; e.alu = 2; e.src = 1; e.ext = 1; end
      K_LUI:  begin e.lat = 4; e.wb = 1; e.ex = 1; e.alu = 3; e.src = 1; end
      K_LW:   begin e.lat = 5; e.wb = 1; e.dat = 1; e.mem = 1; e.lw = 1; e.ex = 1; e.src = 1; end
      K_SW:   begin e.lat = 4; e.mem = 1; e.ex = 1; e.src = 1; end
      K_BEQ:  begin e.lat = 3; e.beq = 1; e.ex = 1; e.alu = 1; end
      K_J:    begin e.lat = 2; e.cpc = 1; e.cpc_npc = 2; end
      K_JR:   begin e.lat = 2; e.cpc = 1; e.cpc_npc = 3; end
      K_JAL:  begin e.lat = 3; e.wb = 1; e.des = 2; e.dat = 2; e.cpc = 1; e.cpc_npc = 2; end
      K_NOP:  begin e.lat = 2; end
      default: begin e.lat = 2; e.ill = 1; end
    endcase
    return e;
  endfunction

  function automatic logic [31:0] gen_instr(input int k);
    logic [31:0] r;
    r = $urandom();
    case (k)
      0:  gen_instr = {6'h00, r[14:0], 5'd0, 6'h21};
      1:  gen_instr = {6'h00, r[14:0], 5'd0, 6'h23};
      2:  gen_instr = {6'h00, r[4:0], 15'd0, 6'h08};
      3:  gen_instr = {6'h0D, r[25:0]};
      4:  gen_instr = {6'h0F, r[25:0]};
      5:  gen_instr = {6'h23, r[25:0]};
      6:  gen_instr = {6'h2B, r[25:0]};
      7:  gen_instr = {6'h04, r[25:0]};
      8:  gen_instr = {6'h02, r[25:0]};
      9:  gen_instr = {6'h03, r[25:0]};
      10: gen_instr = 32'h0;
      11: gen_instr = {6'h3F, r[25:0]};
      12: gen_instr = {6'h00, r[14:0], 5'd0, 6'h2A};
      default: gen_instr = {6'h00, 5'd0, r[9:0], 5'd3, 6'h00};
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] out_vec();
    return {imReq, dmReq, irWE, pcWE, pcCondWE, nextPCop, aluOp, aluSrc, usExt,
            regDesCtrl, regDataCtrl, regWE, dmWE, dmRE, illegal, 3'b000};
  endfunction

  task automatic check_counters(input string tag);
`ifdef MC_PERF_CNT_EN
    check({tag, "_cycleCnt"}, cycleCnt, m_cyc);
    check({tag, "_instrCnt"}, instrCnt, m_ret);
`else
    check({tag, "_cycleCnt"}, cycleCnt, 0);
    check({tag, "_instrCnt"}, instrCnt, 0);
`endif
  endtask

  // Entered just after a rising edge with the DUT in FETCH; returns at the start of the next fetch.
  task automatic run_instr(input string tag, input logic [31:0] ins, input int im_wait,
                           input int dm_wait);
    exp_t e;
    int cyc, im_cnt, dm_cnt, acc_idx, regwe_idx;
    int n_irwe, n_fpcwe, n_fbad, n_cpcwe, n_regwe, n_dmreq, n_dmre, n_dmwe, n_pcc, n_ill;
    logic [2:0] cpc_npc, pcc_npc, ex_alu;
    logic [1:0] des, dat;
    logic ex_src, ex_ext;
    bit done;
    e = expect_of(classify(ins));
    instr = ins;
    cyc = 0; im_cnt = 0; dm_cnt = 0; acc_idx = -1; regwe_idx = -1;
    n_irwe = 0; n_fpcwe = 0; n_fbad = 0; n_cpcwe = 0; n_regwe = 0;
    n_dmreq = 0; n_dmre = 0; n_dmwe = 0; n_pcc = 0; n_ill = 0;
    cpc_npc = '0; pcc_npc = '0; ex_alu = '0; des = '0; dat = '0; ex_src = 0; ex_ext = 0;
    done = 0;
    while (!done && cyc < 64) begin
      imReady = imReq ? (im_cnt >= im_wait) : 1'($urandom_range(0, 1));
      dmReady = dmReq ? (dm_cnt >= dm_wait) : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (imReq) im_cnt++;
      if (dmReq) begin dm_cnt++; n_dmreq++; end
      if (dmRE) n_dmre++;
      if (dmWE) n_dmwe++;
      if (irWE) begin n_irwe++; acc_idx = cyc; end
      if (pcWE && imReq) begin n_fpcwe++; if (nextPCop != 3'd0) n_fbad++; end
      if (pcWE && !imReq) begin n_cpcwe++; cpc_npc = nextPCop; end
      if (pcCondWE) begin n_pcc++; pcc_npc = nextPCop; end
      if (regWE) begin n_regwe++; regwe_idx = cyc; des = regDesCtrl; dat = regDataCtrl; end
      if (illegal) n_ill++;
      if (acc_idx >= 0 && cyc == acc_idx + 2) begin
        ex_alu = aluOp; ex_src = aluSrc; ex_ext = usExt;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (acc_idx >= 0 && imReq) done = 1;
    end
    check({tag, "_completes"}, done, 1);
    check({tag, "_cycles"}, cyc, e.lat + im_wait + (e.mem ? dm_wait : 0));
    check({tag, "_irWE"}, n_irwe, 1);
    check({tag, "_fetch_pcWE"}, {n_fpcwe, n_fbad}, {32'd1, 32'd0});
    check({tag, "_regWE"}, n_regwe, e.wb);
    if (e.wb) check({tag, "_wb_last_dst_data"}, {regwe_idx, des, dat}, {cyc - 1, e.des, e.dat});
    check({tag, "_dmReq"}, n_dmreq, e.mem ? dm_wait + 1 : 0);
    check({tag, "_dmRE_dmWE"}, {n_dmre, n_dmwe},
          {(e.mem && e.lw) ? dm_wait + 1 : 0, (e.mem && !e.lw) ? dm_wait + 1 : 0});
    check({tag, "_pcCondWE"}, n_pcc, e.beq);
    if (e.beq) check({tag, "_branch_npc"}, pcc_npc, 1);
    check({tag, "_ctrl_pcWE"}, n_cpcwe, e.cpc);
    if (e.cpc) check({tag, "_jump_npc"}, cpc_npc, e.cpc_npc);
    check({tag, "_illegal"}, n_ill, e.ill);
    if (e.ex) check({tag, "_exec_alu"}, {ex_alu, ex_src, ex_ext}, {e.alu, e.src, e.ext});
    if (done) m_ret++;
    check_counters(tag);
  endtask

  initial begin
    reset   = 1'b0;
    instr   = 32'h0;
    imReady = 1'b1;
    dmReady = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", out_vec(), 0);
    check_counters("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_idle", out_vec(), 0);
    @(posedge clk);
    #1;
    check("first_fetch_req", imReq, 1);

    run_instr("addu", 32'h00221821, 0, 0);
    run_instr("lw_dm3", 32'h8C220004, 0, 3);
    run_instr("beq", 32'h10000003, 0, 0);
    run_instr("jal", 32'h0C000010, 0, 0);
    run_instr("op3f", 32'hFC000000, 0, 0);
    run_instr("nop", 32'h00000000, 1, 0);
    run_instr("sw_im2", 32'hAC220008, 2, 1);

    // Reset while a store waits in MEM.
    instr   = 32'hAC220008;
    imReady = 1'b1;
    dmReady = 1'b0;
    for (int k = 0; k < 20 && !dmReq; k++) begin
      @(posedge clk);
      #1;
    end
    check("rst_mem_reached", {dmReq, dmWE}, 2'b11);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    m_ret = 0;
    check("rst_dmReq_dmWE", {dmReq, dmWE}, 2'b00);
    check("rst_outputs", out_vec(), 0);
    check_counters("rst");
    reset   = 1'b1;
    imReady = 1'b0;
    @(posedge clk);
    #1;
    check("rst_refetch", imReq, 1);

    for (int i = 0; i < 150; i++) begin
      logic [31:0] ins;
      ins = gen_instr($urandom_range(0, 13));
      run_instr($sformatf("rnd%0d", i), ins, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
